// File: rtl/axis_restore.sv
// axis_restore: 2-stage elastic pipeline that restores a folded coordinate about a symmetry axis.
// Build option: define AXIS_RESTORE_SATURATE_EN to clamp overflowing results instead of wrapping.
module axis_restore #(
    parameter int M = 4,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+N-1:0]   f_in,
    input  logic [M+N-1:0]   s_in,
    input  logic             refl_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   f_out,
    output logic             ovf_out,
    output logic [15:0]      beat_cnt
);
    localparam int W = M + N;

    logic         run_q;
    logic         v1_q, v1_d;
    logic [W:0]   r1_q, r1_d;
    logic         v2_q, v2_d;
    logic [W-1:0] f2_q, f2_d;
    logic         ovf2_q, ovf2_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         in_xfer, out_xfer, adv1, ovf_c;
    logic [W-1:0] res_c;

    // run_q keeps the input closed until the first clock edge after reset release
    assign out_xfer = v2_q & out_ready;
    assign adv1     = v1_q & (~v2_q | out_ready);
    assign in_ready = run_q & (~v1_q | adv1);
    assign in_xfer  = in_valid & in_ready;
    assign ovf_c    = r1_q[W] ^ r1_q[W-1];

    always_comb begin
        res_c = r1_q[W-1:0];
`ifdef AXIS_RESTORE_SATURATE_EN
        if (ovf_c) begin
            res_c = r1_q[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        v1_d   = v1_q;
        r1_d   = r1_q;
        v2_d   = v2_q;
        f2_d   = f2_q;
        ovf2_d = ovf2_q;
        cnt_d  = cnt_q;
        if (in_xfer) begin
            v1_d = 1'b1;
            r1_d = refl_in ? ({s_in[W-1], s_in} - {f_in[W-1], f_in}) : {f_in[W-1], f_in};
        end else if (adv1) begin
            v1_d = 1'b0;
        end
        if (adv1) begin
            v2_d   = 1'b1;
            f2_d   = res_c;
            ovf2_d = ovf_c;
        end else if (out_xfer) begin
            v2_d = 1'b0;
        end
        if (out_xfer) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            v1_q   <= 1'b0;
            r1_q   <= '0;
            v2_q   <= 1'b0;
            f2_q   <= '0;
            ovf2_q <= 1'b0;
            cnt_q  <= 16'd0;
        end else begin
            run_q  <= 1'b1;
            v1_q   <= v1_d;
            r1_q   <= r1_d;
            v2_q   <= v2_d;
            f2_q   <= f2_d;
            ovf2_q <= ovf2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = v2_q;
    assign f_out     = f2_q;
    assign ovf_out   = ovf2_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_axis_restore.sv
// tb_axis_restore: directed, self-checking bench for axis_restore (M=4, N=8).
// Honours AXIS_RESTORE_SATURATE_EN for the expected overflow results.
module tb_axis_restore;
    localparam int M = 4;
    localparam int N = 8;
    localparam int W = M + N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] f_in = '0;
    logic [W-1:0] s_in = '0;
    logic         refl_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] f_out;
    logic         ovf_out;
    logic [15:0]  beat_cnt;

    int           assertCount = 0;
    int           failCount = 0;
    logic [15:0]  expCnt = 16'd0;
    int           firstBlock;
    int           streamCycles;
    logic [W-1:0] qF[$];
    logic [W-1:0] qS[$];
    logic [W-1:0] qEf[$];
    logic         qR[$];
    logic         qEo[$];

`ifdef AXIS_RESTORE_SATURATE_EN
    localparam logic [W-1:0] POS_OVF = 12'h7FF;
    localparam logic [W-1:0] NEG_OVF = 12'h800;
`else
    localparam logic [W-1:0] POS_OVF = 12'hFFF;
    localparam logic [W-1:0] NEG_OVF = 12'h7FF;
`endif

    axis_restore #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_in      (f_in),
        .s_in      (s_in),
        .refl_in   (refl_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .ovf_out   (ovf_out),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] f, input logic [W-1:0] s, input logic r);
        in_valid = 1'b1;
        f_in     = f;
        s_in     = s;
        refl_in  = r;
    endtask

    task automatic addBeat(input logic [W-1:0] f, input logic [W-1:0] s, input logic r,
                           input logic [W-1:0] ef, input logic eo);
        qF.push_back(f);
        qS.push_back(s);
        qR.push_back(r);
        qEf.push_back(ef);
        qEo.push_back(eo);
    endtask

    // Streams the queued beats; out_ready is low on cycles whose stallMask bit is set.
    task automatic runStream(input int maxCycles, input logic [31:0] stallMask);
        int n = qF.size();
        int sendIdx = 0;
        int recvIdx = 0;
        int cyc = 0;
        logic sent, got;
        firstBlock = -1;
        while (recvIdx < n && cyc < maxCycles) begin
            out_ready = (cyc < 32) ? ~stallMask[cyc] : 1'b1;
            if (sendIdx < n) applyStimulus(qF[sendIdx], qS[sendIdx], qR[sendIdx]);
            else in_valid = 1'b0;
            @(negedge clk);
            sent = in_valid && in_ready;
            got  = out_valid && out_ready;
            if (in_valid && !in_ready && firstBlock < 0) firstBlock = sendIdx;
            if (out_valid) begin
                if (recvIdx < n) begin
                    checkOutput("stream_f_out", f_out, qEf[recvIdx]);
                    checkOutput("stream_ovf_out", ovf_out, qEo[recvIdx]);
                end else begin
                    checkOutput("extra_beat", out_valid, 1'b0);
                end
            end
            if (got) begin
                recvIdx++;
                expCnt = expCnt + 16'd1;
            end
            @(posedge clk);
            #1;
            if (sent) sendIdx++;
            cyc++;
        end
        in_valid = 1'b0;
        streamCycles = cyc;
        checkOutput("stream_complete", recvIdx, n);
        checkOutput("stream_beat_cnt", beat_cnt, expCnt);
        qF.delete(); qS.delete(); qR.delete(); qEf.delete(); qEo.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_f_out", f_out, 12'h000);
        checkOutput("rst_ovf_out", ovf_out, 1'b0);
        checkOutput("rst_beat_cnt", beat_cnt, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1'b1);

        // Basic restore and two-edge latency
        out_ready = 1'b1;
        applyStimulus(12'h040, 12'h100, 1'b1);
        @(negedge clk);
        checkOutput("basic_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("basic_lat_edge1", out_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("basic_lat_edge2", out_valid, 1'b1);
        checkOutput("basic_f_out", f_out, 12'h0C0);
        checkOutput("basic_ovf_out", ovf_out, 1'b0);
        @(posedge clk);
        #1;
        expCnt = 16'd1;
        checkOutput("basic_beat_cnt", beat_cnt, expCnt);
        checkOutput("basic_drained", out_valid, 1'b0);

        // Pass-through, overflow both directions, and in-range boundaries at full rate
        addBeat(12'hF80, 12'h000, 1'b1, 12'h080, 1'b0);
        addBeat(12'hF80, 12'h000, 1'b0, 12'hF80, 1'b0);
        addBeat(12'h800, 12'h7FF, 1'b1, POS_OVF, 1'b1);
        addBeat(12'h001, 12'h800, 1'b1, NEG_OVF, 1'b1);
        addBeat(12'h000, 12'h7FF, 1'b1, 12'h7FF, 1'b0);
        addBeat(12'h800, 12'h7FF, 1'b0, 12'h800, 1'b0);
        runStream(40, 32'h0);
        checkOutput("full_rate_cycles", streamCycles, 8);

        // Backpressure: six stalled cycles against four back-to-back beats
        addBeat(12'h001, 12'h010, 1'b1, 12'h00F, 1'b0);
        addBeat(12'h002, 12'h010, 1'b1, 12'h00E, 1'b0);
        addBeat(12'h003, 12'h010, 1'b1, 12'h00D, 1'b0);
        addBeat(12'h004, 12'h010, 1'b1, 12'h00C, 1'b0);
        runStream(40, 32'h3F);
        checkOutput("bp_in_ready_fall", firstBlock, 2);

        // Reset with two beats in flight
        out_ready = 1'b0;
        applyStimulus(12'h123, 12'h000, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(12'h456, 12'h000, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("mid_inflight", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expCnt = 16'd0;
        checkOutput("mid_rst_out_valid", out_valid, 1'b0);
        checkOutput("mid_rst_beat_cnt", beat_cnt, expCnt);
        checkOutput("mid_rst_in_ready", in_ready, 1'b0);
        checkOutput("mid_rst_f_out", f_out, 12'h000);
        checkOutput("mid_rst_ovf_out", ovf_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("mid_no_stale", out_valid, 1'b0);
        end
        checkOutput("mid_cnt_idle", beat_cnt, 16'h0000);
        @(posedge clk);
        #1;

        // Counter wrap after 65537 output transfers
        for (int i = 0; i < 65537; i++) begin
            addBeat(i[11:0], 12'h000, 1'b0, i[11:0], 1'b0);
        end
        runStream(70000, 32'h0);
        checkOutput("wrap_beat_cnt", beat_cnt, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/axis_restore.md
AXIS_RESTORE -- requirements
Module: axis_restore

Interface
REQ-001 SHALL have parameter M, default 4: integer bits of the coordinate, MSB is the sign bit.
REQ-002 SHALL have parameter N, default 8: fractional bits of the coordinate; word width W = M+N.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  the input beat is valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts the input beat this cycle.
REQ-007 SHALL have port f_in  input  W  signed folded coordinate.
REQ-008 SHALL have port s_in  input  W  signed symmetry axis value.
REQ-009 SHALL have port refl_in  input  1  1 = beat was reflected and is restored as s_in-f_in; 0 = pass f_in unchanged.
REQ-010 SHALL have port out_valid  output  1  the output beat is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the output beat.
REQ-012 SHALL have port f_out  output  W  signed restored coordinate.
REQ-013 SHALL have port ovf_out  output  1  the restore result did not fit in W bits; qualified by out_valid.
REQ-014 SHALL have port beat_cnt  output  16  count of output handshakes, wrapping modulo 2^16.

Function
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 The block SHALL be a 2-stage elastic pipeline. Stage 1 registers the W+1-bit signed result (s_in-f_in if refl_in=1, else sign-extended f_in). Stage 2 registers the final f_out and ovf_out.
REQ-017 Each stage SHALL load when it is empty or when its contents advance in the same cycle.
REQ-018 in_ready SHALL be 1 when stage 1 is empty, or when stage 1 advances this cycle; in_ready MAY depend combinationally on out_ready.
REQ-019 With out_ready held at 1, latency SHALL be 2 cycles, from the input transfer edge to out_valid, and throughput SHALL be 1 beat per cycle.
REQ-020 While out_valid=1 and out_ready=0, f_out, ovf_out and out_valid SHALL hold stable.
REQ-021 No beat SHALL be dropped or duplicated, and output order SHALL equal input order.
REQ-022 ovf_out SHALL be 1 exactly when the W+1-bit result lies outside [-2^(W-1), 2^(W-1)-1]; refl_in=0 beats SHALL always give ovf_out=0.
REQ-023 beat_cnt SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-024 A simultaneous input transfer and output transfer on a full pipeline SHALL be accepted with no bubble.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately clear both stage valid flags, so that out_valid=0.
REQ-026 While rst_n=0, the block SHALL drive in_ready=0, f_out=0, ovf_out=0 and beat_cnt=0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight beats.
REQ-028 After reset deasserts, the first rising edge SHALL permit in_ready=1.

Configuration
REQ-029 The macro AXIS_RESTORE_SATURATE_EN SHALL control overflow handling.
REQ-030 When AXIS_RESTORE_SATURATE_EN is defined, an overflowing result SHALL clamp to 2^(W-1)-1 if positive, or to -2^(W-1) if negative.
REQ-031 When AXIS_RESTORE_SATURATE_EN is not defined, an overflowing result SHALL wrap to the low W bits.
REQ-032 ovf_out SHALL behave identically in both builds.

Verification (M=4, N=8)
REQ-033 Basic restore: s_in=0x100, f_in=0x040, refl_in=1, out_ready=1. Response: f_out=0x0C0, ovf_out=0, out_valid rises 2 cycles after the transfer.
REQ-034 Pass-through: f_in=0xF80, refl_in=1 then refl_in=0 with s_in=0x000. Response: outputs 0x080, then 0xF80, in order, with ovf_out=0.
REQ-035 Overflow: s_in=0x7FF, f_in=0x800, refl_in=1. Response: ovf_out=1. f_out=0xFFF without the macro and 0x7FF with it.
REQ-036 Backpressure: 4 back-to-back beats with out_ready=0 for 6 cycles. Response: in_ready falls after 2 accepted beats, f_out is stable while stalled, and all 4 beats emerge in order after out_ready=1.
REQ-037 Reset mid-stream: rst_n=0 with 2 beats in flight. Response: out_valid=0 and beat_cnt=0 immediately, and no stale beat appears after release.
REQ-038 Counter wrap: 65537 output transfers. Response: beat_cnt=0x0001.
